// File: rtl/ysyx_23060136_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060136_pkg
// Description : Shared types and constants for the EXU2 -> MEU pipeline
//               segment: packed control word, segment entry record and the
//               bubble-slot constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060136_pkg;

    localparam int c_BITS_W = 64;
    localparam int c_INST_W = 32;
    localparam int c_CTRL_W = 14;

    localparam logic [c_BITS_W-1:0] PC_RST = 64'h8000_0000;
    localparam logic [c_INST_W-1:0] NOP    = 32'h0000_0013;

    // MSB first: write_gpr is bit 13, rd_is_x0 is bit 0.
    typedef struct packed {
        logic       write_gpr;
        logic       write_csr_1;
        logic       write_csr_2;
        logic       mem_to_reg;
        logic       write_mem;
        logic [7:0] mem_size;
        logic       rd_is_x0;
    } ctrl_t;

    typedef struct packed {
        logic [c_BITS_W-1:0] pc;
        logic [c_INST_W-1:0] inst;
        logic                commit;
        logic [c_BITS_W-1:0] alu_result;
        logic [c_BITS_W-1:0] store_data;
        logic [c_BITS_W-1:0] csr_wdata;
        logic [4:0]          rd;
        ctrl_t               ctrl;
        logic                halt;
    } seg_entry_t;

    localparam int c_ENTRY_W = $bits(seg_entry_t);

    // Contents of an empty slot: everything zero except pc and inst.
    function automatic seg_entry_t bubble_entry(input logic [c_BITS_W-1:0] pc_rst);
        seg_entry_t e;
        e      = '0;
        e.pc   = pc_rst;
        e.inst = NOP;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060136_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060136_skid_slot
// Description : One segment entry register with valid bit. clear has priority
//               over load and returns the slot to bubble contents.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060136_skid_slot
    import ysyx_23060136_pkg::*;
#(
    parameter logic [63:0] PC_RST_VAL = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [c_ENTRY_W-1:0] d,
    output logic                 valid,
    output logic [c_ENTRY_W-1:0] q
);

    // Entry register: async active-low reset, clear beats load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= bubble_entry(PC_RST_VAL);
        end else if (clear) begin
            valid <= 1'b0;
            q     <= bubble_entry(PC_RST_VAL);
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060136_exu_mem_seg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060136_exu_mem_seg
// Description : EXU2 -> MEU pipeline segment. Valid/ready handshake with a
//               head slot and a skid slot so in_ready is registered. Adds a
//               forwarding tap, trap flush and sticky halt latch.
//               Optional macro YSYX_23060136_SEG_PERF_EN adds saturating
//               64-bit performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060136_exu_mem_seg
    import ysyx_23060136_pkg::*;
#(
    // Entry storage is sized from the package; these must match it.
    parameter int          BITS_W = 64,
    parameter int          INST_W = 32,
    parameter logic [63:0] PC_RST = 64'h8000_0000,
    parameter int          CTRL_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BITS_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_commit,
    input  logic [BITS_W-1:0] in_alu_result,
    input  logic [BITS_W-1:0] in_store_data,
    input  logic [BITS_W-1:0] in_csr_wdata,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_commit,
    output logic [BITS_W-1:0] out_alu_result,
    output logic [BITS_W-1:0] out_store_data,
    output logic [BITS_W-1:0] out_csr_wdata,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_halt,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [BITS_W-1:0] fwd_data,
`ifdef YSYX_23060136_SEG_PERF_EN
    output logic [63:0]       perf_full_cycles,
    output logic [63:0]       perf_bp_cycles,
    output logic [63:0]       perf_flush_kills,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        SEG_EMPTY = 2'd0,
        SEG_ONE   = 2'd1,
        SEG_FULL  = 2'd2
    } seg_state_t;

    seg_state_t r_state;
    seg_state_t w_state_nxt;
    logic       r_halted;
    logic       r_in_ready;
    logic       w_halted_nxt;

    seg_entry_t w_in_entry;
    seg_entry_t w_h_d;
    seg_entry_t w_h_q;
    seg_entry_t w_s_q;
    logic       w_h_valid, w_s_valid;
    logic       w_h_load, w_h_clear, w_s_load, w_s_clear;
    logic       w_accept, w_pop;

    assign w_in_entry.pc         = in_pc;
    assign w_in_entry.inst       = in_inst;
    assign w_in_entry.commit     = in_commit;
    assign w_in_entry.alu_result = in_alu_result;
    assign w_in_entry.store_data = in_store_data;
    assign w_in_entry.csr_wdata  = in_csr_wdata;
    assign w_in_entry.rd         = in_rd;
    assign w_in_entry.ctrl       = ctrl_t'(in_ctrl);
    assign w_in_entry.halt       = in_halt;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = w_h_valid & out_ready;

    ysyx_23060136_skid_slot #(.PC_RST_VAL(PC_RST)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (w_h_load),
        .clear (w_h_clear),
        .d     (w_h_d),
        .valid (w_h_valid),
        .q     (w_h_q)
    );

    ysyx_23060136_skid_slot #(.PC_RST_VAL(PC_RST)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (w_s_load),
        .clear (w_s_clear),
        .d     (w_in_entry),
        .valid (w_s_valid),
        .q     (w_s_q)
    );

    // Slot steering and next count state; flush overrides everything.
    always_comb begin
        w_h_load    = 1'b0;
        w_h_clear   = 1'b0;
        w_h_d       = w_in_entry;
        w_s_load    = 1'b0;
        w_s_clear   = 1'b0;
        w_state_nxt = r_state;
        if (flush) begin
            w_h_clear   = 1'b1;
            w_s_clear   = 1'b1;
            w_state_nxt = SEG_EMPTY;
        end else begin
            case (r_state)
                SEG_EMPTY: begin
                    if (w_accept) begin
                        w_h_load    = 1'b1;
                        w_state_nxt = SEG_ONE;
                    end
                end
                SEG_ONE: begin
                    if (w_accept && w_pop) begin
                        w_h_load = 1'b1;
                    end else if (w_accept) begin
                        w_s_load    = 1'b1;
                        w_state_nxt = SEG_FULL;
                    end else if (w_pop) begin
                        w_h_clear   = 1'b1;
                        w_state_nxt = SEG_EMPTY;
                    end
                end
                SEG_FULL: begin
                    if (w_pop) begin
                        w_h_load    = 1'b1;
                        w_h_d       = w_s_q;
                        w_s_clear   = 1'b1;
                        w_state_nxt = SEG_ONE;
                    end
                end
                default: begin
                    w_h_clear   = 1'b1;
                    w_s_clear   = 1'b1;
                    w_state_nxt = SEG_EMPTY;
                end
            endcase
        end
    end

    // A dropped (flushed) halt instruction never latches the halt.
    assign w_halted_nxt = r_halted | (w_accept & in_halt & ~flush);

    // Count FSM, sticky halt and the registered in_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SEG_EMPTY;
            r_halted   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_halted   <= w_halted_nxt;
            r_in_ready <= (w_state_nxt != SEG_FULL) & ~w_halted_nxt;
        end
    end

    assign in_ready       = r_in_ready;
    assign halted         = r_halted;
    assign out_valid      = w_h_valid;
    assign out_pc         = w_h_q.pc;
    assign out_inst       = w_h_q.inst;
    assign out_commit     = w_h_q.commit;
    assign out_alu_result = w_h_q.alu_result;
    assign out_store_data = w_h_q.store_data;
    assign out_csr_wdata  = w_h_q.csr_wdata;
    assign out_rd         = w_h_q.rd;
    assign out_ctrl       = w_h_q.ctrl;
    assign out_halt       = w_h_q.halt;

    assign fwd_valid = w_h_valid & w_h_q.ctrl.write_gpr & ~w_h_q.ctrl.mem_to_reg
                     & ~w_h_q.ctrl.rd_is_x0;
    assign fwd_rd    = w_h_q.rd;
    assign fwd_data  = w_h_q.alu_result;

`ifdef YSYX_23060136_SEG_PERF_EN
    logic [63:0] r_perf_full, r_perf_bp, r_perf_kills;
    logic [1:0]  w_kills;
    logic [64:0] w_kills_sum;

    assign w_kills     = {1'b0, w_h_valid} + {1'b0, w_s_valid};
    assign w_kills_sum = {1'b0, r_perf_kills} + {63'd0, w_kills};

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_full  <= '0;
            r_perf_bp    <= '0;
            r_perf_kills <= '0;
        end else begin
            if ((r_state == SEG_FULL) && !(&r_perf_full))
                r_perf_full <= r_perf_full + 64'd1;
            if (w_h_valid && !out_ready && !(&r_perf_bp))
                r_perf_bp <= r_perf_bp + 64'd1;
            if (flush)
                r_perf_kills <= w_kills_sum[64] ? '1 : w_kills_sum[63:0];
        end
    end

    assign perf_full_cycles = r_perf_full;
    assign perf_bp_cycles   = r_perf_bp;
    assign perf_flush_kills = r_perf_kills;
`endif

endmodule
`default_nettype wire

// File: doc/ysyx_23060136_exu_mem_seg.md
Name: ysyx_23060136_exu_mem_seg

Overview:
- Pipeline boundary between EXU2 (branch/ALU resolve) and MEU (load/store unit); sits directly downstream of the EXU1→EXU2 segment.
- Replaces a stall-wire register with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` is a pure register output.
- Also provides a forwarding tap for the hazard unit, a trap-flush path and a sticky halt latch.

Parameters:
- BITS_W, 64, data/PC width
- INST_W, 32, instruction width
- PC_RST, 64'h8000_0000, PC value of an empty/bubble slot
- CTRL_W, 14, width of packed MEU/WB control (`write_gpr`, `write_csr_1/2`, `mem_to_reg`, `write_mem`, 8 mem size bits, `rd_is_x0`)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  trap/redirect kill of every held instruction
- in_valid  in  1  EXU2 offers an instruction
- in_ready  out  1  segment accepts this cycle
- in_pc  in  BITS_W  instruction PC
- in_inst  in  INST_W  raw instruction
- in_commit  in  1  instruction retires (not a bubble)
- in_alu_result  in  BITS_W  ALU result / memory address
- in_store_data  in  BITS_W  rs2 data for stores
- in_csr_wdata  in  BITS_W  CSR write value
- in_rd  in  5  destination GPR
- in_ctrl  in  CTRL_W  packed control
- in_halt  in  1  ebreak/system halt
- out_valid  out  1  head entry valid
- out_ready  in  1  MEU consumes head
- out_pc, out_inst, out_commit, out_alu_result, out_store_data, out_csr_wdata, out_rd, out_ctrl, out_halt  out  as inputs  head-entry fields
- fwd_valid  out  1  head holds a non-load GPR write
- fwd_rd  out  5  head rd
- fwd_data  out  BITS_W  head `alu_result`
- halted  out  1  sticky: a halt instruction has been accepted

Behaviour:
- Storage: head slot H and skid slot S, each with a valid bit. Count state: EMPTY (0), ONE (H only), FULL (H+S). S is never valid while H is invalid.
- `in_ready = ~S.valid & ~halted`, driven purely from registers.
- `out_valid = H.valid`; `out_*` come straight from H registers. No combinational path from `in_*` to `out_*`.
- Accept = `in_valid & in_ready`. Pop = `H.valid & out_ready`.
- EMPTY: accept → ONE, H loads input.
- ONE:
  - accept & pop → ONE, H reloads.
  - accept & ~pop → FULL, S loads.
  - pop & ~accept → EMPTY.
- FULL: pop → ONE, H ← S, S cleared. Accept is impossible in FULL.
- Latency: an input accepted in cycle N appears on `out_*` in cycle N+1 when the segment was EMPTY, or when it was ONE with a pop in cycle N.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Order is strictly FIFO.
- flush: next edge → EMPTY; both valid bits, `commit` and `ctrl` cleared; `pc = PC_RST`; `inst = NOP` (32'h13).
  - flush wins over a simultaneous accept (input dropped) and over a pop (the pop still counts as consumed by MEU).
  - flush does NOT clear `halted`.
- Halt: accepting an entry with `in_halt=1` sets `halted` on the same edge. From then on `in_ready=0` until reset; entries already held still drain normally.
- Forwarding:
  - `fwd_valid = H.valid & ctrl.write_gpr & ~ctrl.mem_to_reg & ~ctrl.rd_is_x0`.
  - `fwd_rd` and `fwd_data` are always driven from H, even when `fwd_valid=0`.
- Bubble slots: all `out_*` hold reset values (`pc=PC_RST`, `inst=NOP`, others 0).
- Reset, asserted at any time including mid-transfer: all state immediately cleared.
  - `out_valid=0`, `halted=0`, `in_ready=1` after release.
  - All data outputs at reset values.

Optional Feature:
- Macro: YSYX_23060136_SEG_PERF_EN.
- Defined: adds three 64-bit outputs, all reset to 0, saturating at all-ones:
  - `perf_full_cycles`: cycles in FULL.
  - `perf_bp_cycles`: cycles with `out_valid & ~out_ready`.
  - `perf_flush_kills`: number of valid entries discarded by flush.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package `ysyx_23060136_pkg`:
  - `seg_entry_t` struct (pc, inst, commit, alu_result, store_data, csr_wdata, rd, ctrl, halt).
  - `ctrl_t` packed struct.
  - `NOP` and `PC_RST` constants.
- One natural sub-module: `ysyx_23060136_skid_slot`, a single entry register with load/clear/valid, instantiated twice.
- The top module holds the count FSM, halt latch, forwarding and perf logic.

Test Plan:
- Streaming: `out_ready=1`, 4 back-to-back inputs with pc 0x80000000..0x8000000C → outputs in order one cycle later; `in_ready` stays 1; FSM never reaches FULL.
- Backpressure: `out_ready=0`, offer pc A, then B, then C → A in H, B in S, `in_ready=0` while C is held. Release `out_ready` → outputs A, B, C in consecutive cycles.
- Flush in FULL with simultaneous accept attempt → next cycle `out_valid=0`, `out_pc=0x80000000`, `out_inst=0x13`, `in_ready=1`. The dropped input never appears.
- Halt: accept `in_halt=1` at pc 0x80000100 while an entry is held → `halted=1` and `in_ready=0` from the next cycle. Both held entries drain; flush leaves `halted=1`; a later `rst` pulse clears it.
- Forwarding:
  - head `addi x5` with result 0x1234 → `fwd_valid=1`, `fwd_rd=5`, `fwd_data=0x1234`.
  - a load to x5 or any write to x0 → `fwd_valid=0`.
- Async reset asserted mid-cycle while FULL → outputs clear without waiting for a clock edge; with PERF_EN, all counters read 0.
